// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
//
// Shared definitions for the up/down counter sequencers used in the FIR/CNN
// address and tap generators.
//
// Contents:
//   counter_state_t : two-state sequencer FSM encoding (IDLE, COUNTING)
// ----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } counter_state_t;

endpackage : counter_pkg

// File: rtl/down_counter_enabled.sv
// ----------------------------------------------------------------------------
// down_counter_enabled
//
// Countdown sequencer.  On start it presents INPUT_MAX, INPUT_MAX-1, ... 0 to
// a downstream consumer, one value per accepted beat, with a global enable
// that freezes everything except reset.  Used to walk buffers and tap tables
// in reverse order.
//
// Handshake: a beat is transferred on a rising edge where valid_o, ready_i
// and en_i are all 1.  Once valid_o is raised, data_o and valid_o stay stable
// until that beat is transferred; valid_o never depends combinationally on
// ready_i.
//
// Parameters:
//   WORD_SIZE : width of data_o
//   INPUT_MAX : first value of every sequence (0 <= INPUT_MAX < 2^WORD_SIZE)
//
// Ports:
//   clk_i    in   clock, all state changes on the rising edge
//   reset_i  in   synchronous active-low reset (0 = reset)
//   start_i  in   begin a sequence, sampled only in IDLE
//   en_i     in   global enable, 0 freezes all state except reset
//   ready_i  in   consumer can accept data_o this cycle
//   data_o   out  current count value
//   valid_o  out  data_o is valid (registered)
//   last_o   out  valid_o high and data_o == 0 (decoded)
//   busy_o   out  a sequence is in progress (decoded from state)
//   done_o   out  one-cycle pulse after the final beat is accepted (registered)
//   state_o  out  current FSM state, for observation
// ----------------------------------------------------------------------------
module down_counter_enabled
    import counter_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned INPUT_MAX = 10
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 en_i,
    input  logic                 ready_i,
    output logic [WORD_SIZE-1:0] data_o,
    output logic                 valid_o,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 done_o,
    output counter_state_t       state_o
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (WORD_SIZE < 1) begin : g_bad_word_size
        $error("down_counter_enabled: WORD_SIZE must be at least 1");
    end

    // Widths of 32 or more hold any int unsigned INPUT_MAX, so only narrower
    // words need the range check (the shift would overflow otherwise).
    if ((WORD_SIZE < 32) && (64'(INPUT_MAX) >= (64'd1 << WORD_SIZE))) begin : g_bad_input_max
        $error("down_counter_enabled: INPUT_MAX does not fit in WORD_SIZE bits");
    end

    localparam logic [WORD_SIZE-1:0] LOAD_VALUE = WORD_SIZE'(INPUT_MAX);
    localparam logic [WORD_SIZE-1:0] ZERO       = '0;
    localparam logic [WORD_SIZE-1:0] ONE        = WORD_SIZE'(1);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    counter_state_t         state_q, state_d;
    logic [WORD_SIZE-1:0]   data_q,  data_d;
    logic                   valid_q, valid_d;
    logic                   done_q,  done_d;

    logic                   transfer;
    logic                   final_beat;

    assign transfer   = valid_q && ready_i && en_i;
    assign final_beat = (data_q == ZERO);

    // ------------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        // With en_i low everything holds; done_d stays at its default of 0
        // so a frozen pipeline never reports completion.
        if (en_i) begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = COUNTING;
                        data_d  = LOAD_VALUE;
                        valid_d = 1'b1;
                    end else begin
                        data_d  = ZERO;
                        valid_d = 1'b0;
                    end
                end

                COUNTING: begin
                    if (transfer) begin
                        if (final_beat) begin
                            // The 0 beat closes the sequence, so the
                            // decrement below can never wrap.
                            state_d = IDLE;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            data_d  = data_q - ONE;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    data_d  = ZERO;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            data_q  <= ZERO;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign last_o  = valid_q && final_beat;
    assign busy_o  = (state_q == COUNTING);
    assign state_o = state_q;

endmodule : down_counter_enabled

// File: tb/tb_down_counter_enabled.sv
// ----------------------------------------------------------------------------
// tb_down_counter_enabled
//
// Two instances share every input: one with INPUT_MAX = 10, one with
// INPUT_MAX = 0.  A reference model holds, per instance, the queue of values
// still to be delivered; the head of the queue is the expected data_o and a
// non-empty queue means valid/busy.  Outputs are compared on the falling edge.
// ----------------------------------------------------------------------------
module tb_down_counter_enabled;
    import counter_pkg::*;

    localparam int W = 16;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic en      = 1'b0;
    logic ready   = 1'b0;

    logic [W-1:0]   data0, data1;
    logic           valid0, valid1, last0, last1, busy0, busy1, done0, done1;
    counter_state_t st0, st1;

    down_counter_enabled #(.WORD_SIZE(W), .INPUT_MAX(10)) dut (
        .clk_i(clk), .reset_i(reset_n), .start_i(start), .en_i(en),
        .ready_i(ready), .data_o(data0), .valid_o(valid0), .last_o(last0),
        .busy_o(busy0), .done_o(done0), .state_o(st0)
    );

    down_counter_enabled #(.WORD_SIZE(W), .INPUT_MAX(0)) dut_zero (
        .clk_i(clk), .reset_i(reset_n), .start_i(start), .en_i(en),
        .ready_i(ready), .data_o(data1), .valid_o(valid1), .last_o(last1),
        .busy_o(busy1), .done_o(done1), .state_o(st1)
    );

    // ------------------------------------------------------------------------
    // Scoreboard / reference model
    // ------------------------------------------------------------------------
    int          errors = 0;
    int          checks = 0;
    bit          chk_on = 1'b0;
    logic [W-1:0] exp_q [2][$];
    bit          exp_done [2];
    int          max_v [2] = '{10, 0};

    task automatic chk(input string tag, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic         e_valid;
            logic [W-1:0] e_data;
            e_valid = (exp_q[k].size() > 0);
            e_data  = e_valid ? exp_q[k][0] : '0;
            chk("data",  k, (k == 0) ? 32'(data0)  : 32'(data1),  32'(e_data));
            chk("valid", k, (k == 0) ? 32'(valid0) : 32'(valid1), 32'(e_valid));
            chk("last",  k, (k == 0) ? 32'(last0)  : 32'(last1),
                32'(e_valid && (e_data == '0)));
            chk("busy",  k, (k == 0) ? 32'(busy0)  : 32'(busy1),  32'(e_valid));
            chk("done",  k, (k == 0) ? 32'(done0)  : 32'(done1),  32'(exp_done[k]));
            chk("state", k, (k == 0) ? 32'(st0 == COUNTING) : 32'(st1 == COUNTING),
                32'(e_valid));
        end
    endtask

    // Advance the model across one rising edge using the inputs in force.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                exp_q[k].delete();
                exp_done[k] = 1'b0;
            end else if (!en) begin
                exp_done[k] = 1'b0;
            end else begin
                bit nd;
                nd = 1'b0;
                if (exp_q[k].size() > 0) begin
                    if (ready) begin
                        void'(exp_q[k].pop_front());
                        nd = (exp_q[k].size() == 0);
                    end
                end else if (start) begin
                    for (int v = max_v[k]; v >= 0; v--) exp_q[k].push_back(W'(v));
                end
                exp_done[k] = nd;
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        if (chk_on) check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Run until the wide instance has finished its sequence (bounded).
    task automatic run_to_idle(input int budget);
        int i;
        for (i = 0; i < budget && exp_q[0].size() > 0; i++) tick();
        checks++;
        assert (i < budget) else begin
            errors++;
            $error("FAIL run_to_idle observed=timeout expected=idle within %0d", budget);
        end
    endtask

    task automatic run_to_value(input logic [W-1:0] v, input int budget);
        int i;
        for (i = 0; i < budget && !(exp_q[0].size() > 0 && exp_q[0][0] == v); i++) tick();
        checks++;
        assert (i < budget) else begin
            errors++;
            $error("FAIL run_to_value observed=timeout expected=data %0d", v);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        // Reset: settle both DUTs before checking starts.
        reset_n = 1'b0; en = 1'b1; ready = 1'b1; start = 1'b0;
        ticks(2);
        chk_on = 1'b1;
        tick();                        // reset state
        reset_n = 1'b1;
        ticks(2);                      // idle, no start

        // Basic run, one beat per cycle, done pulse afterwards.
        pulse_start();
        run_to_idle(20);
        ticks(2);

        // Backpressure at data 7 for 3 cycles.
        pulse_start();
        run_to_value(16'd7, 20);
        ready = 1'b0;
        ticks(3);
        ready = 1'b1;
        run_to_idle(20);
        ticks(1);

        // Enable low for 4 cycles mid-run.
        pulse_start();
        ticks(3);
        en = 1'b0;
        ticks(4);
        en = 1'b1;
        run_to_idle(20);
        ticks(1);

        // start while disabled and idle is dropped.
        en = 1'b0;
        pulse_start();
        en = 1'b1;
        ticks(2);

        // start held during counting is ignored; start in the done cycle
        // launches the next sequence.
        pulse_start();
        ticks(2);
        start = 1'b1;
        ticks(3);
        start = 1'b0;
        for (int i = 0; i < 20 && !exp_done[0]; i++) tick();
        start = 1'b1;                  // presented in the done cycle
        tick();
        start = 1'b0;
        tick();

        // Reset mid-sequence at data 5, two cycles low, no done afterwards.
        run_to_value(16'd5, 20);
        reset_n = 1'b0;
        ticks(2);
        reset_n = 1'b1;
        ticks(4);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            ready   = ($urandom_range(0, 3) != 0);
            en      = ($urandom_range(0, 7) != 0);
            start   = ($urandom_range(0, 3) == 0);
            reset_n = ($urandom_range(0, 31) != 0);
            tick();
        end
        reset_n = 1'b1; en = 1'b1; ready = 1'b1; start = 1'b0;
        run_to_idle(40);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_down_counter_enabled
